// File: rtl/key_scan_pkg.sv
// Shared definitions for the keypad scanner: ModeKey command bits, key map and FSM states.
package key_scan_pkg;

    localparam logic [7:0] MK_UP      = 8'h01;
    localparam logic [7:0] MK_DOWN    = 8'h02;
    localparam logic [7:0] MK_LEFT    = 8'h04;
    localparam logic [7:0] MK_RIGHT   = 8'h08;
    localparam logic [7:0] MK_RESTART = 8'h10;
    localparam logic [7:0] MK_MODE1   = 8'h20;
    localparam logic [7:0] MK_MODE2   = 8'h40;
    localparam logic [7:0] MK_UNDO    = 8'h80;

    // Indexed by key code row*4+col; zero entries are keys with no command.
    localparam logic [7:0] KEYMAP [16] = '{
        MK_RESTART, MK_UP,  8'h00,    8'h00,
        MK_LEFT,    8'h00,  MK_RIGHT, 8'h00,
        8'h00,      MK_DOWN, 8'h00,   8'h00,
        MK_MODE1,   MK_MODE2, 8'h00,  MK_UNDO
    };

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD,
        RELEASE
    } state_t;

    function automatic logic [1:0] low_row(input logic [3:0] pat_n);
        logic [1:0] r;
        r = 2'd3;
        if (!pat_n[2]) r = 2'd2;
        if (!pat_n[1]) r = 2'd1;
        if (!pat_n[0]) r = 2'd0;
        return r;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage

// File: rtl/key_debounce_sync.sv
// Row input synchronizer and the scan divider that marks each column's sample point.
module key_debounce_sync #(
    parameter int SCAN_DIV = 32768
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] row_sync,
    output logic       sample
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [3:0]    row_meta;
    logic [DW-1:0] div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '1;
            row_sync <= '1;
            div_cnt  <= '0;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
            div_cnt  <= sample ? '0 : div_cnt + DW'(1);
        end
    end

    assign sample = (div_cnt == DW'(SCAN_DIV - 1));

endmodule

// File: rtl/key_scan_encoder.sv
// 4x4 keypad scanner: debounces a press in the driven column, emits a held one-hot ModeKey
// command, then waits for a debounced release before scanning resumes.
module key_scan_encoder
    import key_scan_pkg::*;
#(
    parameter int SCAN_DIV       = 32768,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int HOLD_CYCLES    = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] ModeKey,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int DBW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_t         state;
    logic [1:0]     col;
    logic [3:0]     pat_n;
    logic [DBW-1:0] deb_cnt;
    logic [DBW-1:0] rel_cnt;
    logic [HW-1:0]  hold_cnt;
    logic [3:0]     row_sync;
    logic           sample;
    logic [3:0]     key_idx;

    key_debounce_sync #(
        .SCAN_DIV(SCAN_DIV)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .row_n   (row_n),
        .row_sync(row_sync),
        .sample  (sample)
    );

    assign key_idx = {low_row(pat_n), col};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col       <= '0;
            col_n     <= 4'b1110;
            pat_n     <= '1;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            hold_cnt  <= '0;
            ModeKey   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (sample) begin
                        if (row_sync == 4'b1111) begin
                            col   <= col + 2'd1;
                            col_n <= col_drive(col + 2'd1);
                        end else begin
                            pat_n   <= row_sync;
                            deb_cnt <= DBW'(1);
                            state   <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (sample) begin
                        if (row_sync != pat_n) begin
                            deb_cnt <= '0;
                            col     <= col + 2'd1;
                            col_n   <= col_drive(col + 2'd1);
                            state   <= SCAN;
                        end else if (deb_cnt == DBW'(DEBOUNCE_SCANS - 1)) begin
                            // This matching sample is the DEBOUNCE_SCANS-th one: accept now.
                            deb_cnt   <= '0;
                            key_code  <= key_idx;
                            key_valid <= 1'b1;
                            ModeKey   <= KEYMAP[key_idx];
                            hold_cnt  <= '0;
                            state     <= HOLD;
                        end else begin
                            deb_cnt <= deb_cnt + DBW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        ModeKey  <= '0;
                        hold_cnt <= '0;
                        rel_cnt  <= '0;
                        state    <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RELEASE: begin
                    if (sample) begin
                        if (row_sync != 4'b1111) begin
                            rel_cnt <= '0;
                        end else if (rel_cnt == DBW'(DEBOUNCE_SCANS - 1)) begin
                            rel_cnt <= '0;
                            col     <= col + 2'd1;
                            col_n   <= col_drive(col + 2'd1);
                            state   <= SCAN;
                        end else begin
                            rel_cnt <= rel_cnt + DBW'(1);
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_key_scan_encoder.sv
// Scoreboarded bench for key_scan_encoder: a keypad model drives rows from the column drive,
// expected acceptances are queued at press time and checked when key_valid appears.
module tb_key_scan_encoder;

    localparam int SD = 4;
    localparam int DS = 3;
    localparam int HC = 20;

    typedef struct packed {
        logic [3:0] code;
        logic [7:0] mk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [7:0]  ModeKey;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] keys = '0;

    int   errors = 0;
    int   checks = 0;
    exp_t expq[$];
    exp_t e;
    int   mk_len = 0;
    int   kv_len = 0;
    logic [3:0] cols [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    key_scan_encoder #(
        .SCAN_DIV      (SD),
        .DEBOUNCE_SCANS(DS),
        .HOLD_CYCLES   (HC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .ModeKey  (ModeKey),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    // Keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on key_valid, also checks pulse width and ModeKey hold length.
    always @(negedge clk) begin
        if (rst) begin
            mk_len = 0;
            kv_len = 0;
        end else begin
            if (key_valid) begin
                kv_len++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key_valid: key_code=%0d with no pending press", key_code);
                end else begin
                    e = expq.pop_front();
                    check("key_code", 32'(key_code), 32'(e.code));
                    check("ModeKey_at_accept", 32'(ModeKey), 32'(e.mk));
                end
            end else if (kv_len != 0) begin
                check("key_valid_width", kv_len, 1);
                kv_len = 0;
            end
            if (ModeKey != 8'h00) mk_len++;
            else if (mk_len != 0) begin
                check("ModeKey_hold_len", mk_len, HC);
                mk_len = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns just after the edge at which column c starts being driven.
    task automatic wait_col(input logic [3:0] c);
        int n;
        n = 0;
        while (col_n == c && n < 200) begin cyc(1); n++; end
        n = 0;
        while (col_n != c && n < 200) begin cyc(1); n++; end
        if (col_n != c) begin
            checks++;
            errors++;
            $display("FAIL wait_col: col_n=%b never reached %b", col_n, c);
        end
    endtask

    task automatic wait_valid(input int lim);
        int n;
        n = 0;
        while (!key_valid && n < lim) begin cyc(1); n++; end
        if (!key_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: key_valid=0 after %0d cycles, required 1", lim);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col_n", 32'(col_n), 32'h e);
        check("rst_ModeKey", 32'(ModeKey), 0);
        check("rst_key_code", 32'(key_code), 0);
        check("rst_key_valid", 32'(key_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle scan rotation
        for (int k = 1; k <= 4; k++) begin
            cyc(SD);
            check("scan_col", 32'(col_n), 32'(cols[k % 4]));
            check("idle_ModeKey", 32'(ModeKey), 0);
        end

        // Key 1 held: one acceptance, ModeKey UP for HC cycles, no retrigger
        wait_col(4'b1101);
        keys[1] = 1'b1;
        expq.push_back(exp_t'{4'd1, 8'h01});
        wait_valid(100);
        cyc(100);
        check("held_col_n", 32'(col_n), 32'(4'b1101));
        keys = '0;
        cyc(40);

        // Bounce: visible to a single sample, then scanning moves on
        wait_col(4'b1101);
        keys[1] = 1'b1;
        cyc(4);
        keys[1] = 1'b0;
        cyc(4);
        check("bounce_resume_col", 32'(col_n), 32'(4'b1011));
        check("bounce_no_valid", 32'(key_valid), 0);
        wait_col(4'b1101);
        keys[1] = 1'b1;
        expq.push_back(exp_t'{4'd1, 8'h01});
        cyc(8);
        check("deb_2_samples_valid", 32'(key_valid), 0);
        cyc(3);
        check("deb_pre_accept_ModeKey", 32'(ModeKey), 0);
        cyc(1);
        check("deb_accept_valid", 32'(key_valid), 1);
        check("deb_accept_ModeKey", 32'(ModeKey), 32'h01);
        keys = '0;
        cyc(40);

        // Unmapped key 5
        wait_col(4'b1101);
        keys[5] = 1'b1;
        expq.push_back(exp_t'{4'd5, 8'h00});
        wait_valid(100);
        cyc(5);
        check("unmapped_ModeKey", 32'(ModeKey), 0);
        keys = '0;
        cyc(40);

        // Key 9: release needs 3 consecutive high samples; a re-press resets the count
        wait_col(4'b1101);
        keys[9] = 1'b1;
        expq.push_back(exp_t'{4'd9, 8'h02});
        wait_valid(100);
        cyc(24);
        keys[9] = 1'b0;
        cyc(9);
        keys[9] = 1'b1;
        cyc(4);
        keys[9] = 1'b0;
        cyc(8);
        check("release_2_high_col", 32'(col_n), 32'(4'b1101));
        cyc(4);
        check("release_done_col", 32'(col_n), 32'(4'b1011));
        wait_col(4'b0111);
        keys[15] = 1'b1;
        expq.push_back(exp_t'{4'd15, 8'h80});
        wait_valid(100);
        keys = '0;
        cyc(40);

        // Reset during HOLD; key still held at release is a new press
        wait_col(4'b1101);
        keys[9] = 1'b1;
        expq.push_back(exp_t'{4'd9, 8'h02});
        wait_valid(100);
        cyc(5);
        check("hold_before_rst", 32'(ModeKey), 32'h02);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ModeKey", 32'(ModeKey), 0);
        check("async_rst_col_n", 32'(col_n), 32'he);
        check("async_rst_key_code", 32'(key_code), 0);
        check("async_rst_key_valid", 32'(key_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expq.push_back(exp_t'{4'd9, 8'h02});
        wait_valid(100);
        keys = '0;
        cyc(60);

        check("queue_drained", 32'(expq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
